// File: rtl/star_pkg.sv
// Shared types and constants for the star spawn request path.
// Holds the request struct, LFSR constants and the queue occupancy states.
package star_pkg;

    localparam int          STAR_ID_BITS  = 4;
    localparam int          STAR_X_BITS   = 10;
    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

    typedef struct packed {
        logic [STAR_X_BITS-1:0]  x;
        logic [STAR_ID_BITS-1:0] id;
    } star_req_t;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_t;

    // Galois right-shift step; a zero state would lock up, so callers never seed with 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/star_req_fifo.sv
// Small synchronous FIFO of star requests with a registered head entry.
// Caller guarantees push only when not full (or popping) and pop only when valid.
module star_req_fifo
    import star_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      resetN,
    input  logic      i_push,
    input  logic      i_pop,
    input  star_req_t i_data,
    output star_req_t o_head,
    output logic      o_valid,
    output logic      o_full
);

    localparam int AW = $clog2(DEPTH);

    star_req_t      r_mem [DEPTH];
    star_req_t      r_head;
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_cnt;
    q_state_t       r_state;
    q_state_t       w_state_nxt;
    logic [AW:0]    w_cnt_nxt;
    logic [AW:0]    w_cnt_rem;
    logic [AW-1:0]  w_rd_nxt;

    always_comb begin
        w_cnt_rem = r_cnt - (AW+1)'(i_pop);
        w_cnt_nxt = w_cnt_rem + (AW+1)'(i_push);
        w_rd_nxt  = r_rd + AW'(i_pop);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            Q_EMPTY:   if (i_push) w_state_nxt = (w_cnt_nxt == (AW+1)'(DEPTH)) ? Q_FULL : Q_PARTIAL;
            Q_PARTIAL: begin
                if (w_cnt_nxt == (AW+1)'(DEPTH))  w_state_nxt = Q_FULL;
                else if (w_cnt_nxt == '0)         w_state_nxt = Q_EMPTY;
            end
            Q_FULL:    if (i_pop && !i_push) w_state_nxt = Q_PARTIAL;
            default:   w_state_nxt = Q_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= Q_EMPTY;
            r_cnt   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_head  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd    <= w_rd_nxt;
            if (i_push) r_wr <= r_wr + AW'(1);
            // New head comes from the incoming entry only when nothing older remains.
            if (i_push && w_cnt_rem == '0)
                r_head <= i_data;
            else if (i_pop && w_cnt_rem != '0)
                r_head <= r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_head;
    assign o_valid = (r_state != Q_EMPTY);
    assign o_full  = (r_state == Q_FULL);

endmodule

// File: rtl/star_spawn_queue.sv
// Captures an LFSR-derived X coordinate and sequence ID on each enabled put_star tick.
// Optional saturating drop counter built when STAR_SPAWN_DROP_CNT_EN is defined.
module star_spawn_queue
    import star_pkg::*;
#(
    parameter int          X_BITS = 10,
    parameter int          X_MIN  = 0,
    parameter int          X_MAX  = 639,
    parameter int          DEPTH  = 4,
    parameter logic [15:0] SEED   = 16'h0001
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              put_star,
    input  logic              enable,
    input  logic              star_ready,
    output logic              star_valid,
    output logic [X_BITS-1:0] star_x,
    output logic [3:0]        star_id,
    output logic              full
`ifdef STAR_SPAWN_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int          RANGE     = X_MAX - X_MIN + 1;
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? LFSR_ZERO_SUB : SEED;

    logic [15:0]             r_lfsr;
    logic [STAR_ID_BITS-1:0] r_id_ctr;
    logic [X_BITS-1:0]       w_raw;
    logic [X_BITS-1:0]       w_fold;
    logic [X_BITS-1:0]       w_x;
    logic                    w_req;
    logic                    w_pop;
    logic                    w_push;
    star_req_t               w_data;
    star_req_t               w_head;

    // Range fits within one fold because RANGE >= 2^(X_BITS-1).
    always_comb begin
        w_raw  = r_lfsr[X_BITS-1:0];
        w_fold = (w_raw > X_BITS'(X_MAX - X_MIN)) ? (w_raw - X_BITS'(RANGE)) : w_raw;
        w_x    = w_fold + X_BITS'(X_MIN);
        w_data = '{x: STAR_X_BITS'(w_x), id: r_id_ctr};
    end

    assign w_req  = put_star && enable;
    assign w_pop  = star_valid && star_ready;
    assign w_push = w_req && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_lfsr   <= SEED_EFF;
            r_id_ctr <= '0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            if (w_push) r_id_ctr <= r_id_ctr + 1'b1;
        end
    end

`ifdef STAR_SPAWN_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!resetN)
            r_drop_cnt <= '0;
        else if (w_req && !w_push && r_drop_cnt != 8'hFF)
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt = r_drop_cnt;
`endif

    star_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_data),
        .o_head  (w_head),
        .o_valid (star_valid),
        .o_full  (full)
    );

    assign star_x  = X_BITS'(w_head.x);
    assign star_id = w_head.id;

endmodule

// File: tb/tb_star_spawn_queue.sv
// Scoreboard bench for star_spawn_queue: an independent model queues expected
// entries on accepted pushes and compares them as the DUT presents its head.
module tb_star_spawn_queue;

    logic       clk = 1'b0;
    logic       resetN;
    logic       put_star, enable, star_ready;
    logic       star_valid, full;
    logic [9:0] star_x;
    logic [3:0] star_id;
    logic       put2, rdy2;
    logic       valid2, full2;
    logic [9:0] x2;
    logic [3:0] id2;
`ifdef STAR_SPAWN_DROP_CNT_EN
    logic [7:0] drop_cnt, drop2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int x;
        int id;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] m_lfsr;
    int          m_id;
    int          m_drop;

    always #5 clk = ~clk;

    star_spawn_queue u_dut (
        .clk        (clk),
        .resetN     (resetN),
        .put_star   (put_star),
        .enable     (enable),
        .star_ready (star_ready),
        .star_valid (star_valid),
        .star_x     (star_x),
        .star_id    (star_id),
        .full       (full)
`ifdef STAR_SPAWN_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    star_spawn_queue #(.SEED(16'h03FF)) u_dut_seed (
        .clk        (clk),
        .resetN     (resetN),
        .put_star   (put2),
        .enable     (enable),
        .star_ready (rdy2),
        .star_valid (valid2),
        .star_x     (x2),
        .star_id    (id2),
        .full       (full2)
`ifdef STAR_SPAWN_DROP_CNT_EN
        ,
        .drop_cnt   (drop2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'h0001;
        m_id   = 0;
        m_drop = 0;
        sbq.delete();
    endtask

    task automatic check_outputs();
        chk("valid", star_valid, sbq.size() > 0);
        chk("full", full, sbq.size() == 4);
        if (sbq.size() > 0) begin
            chk("head_x", star_x, sbq[0].x);
            chk("head_id", star_id, sbq[0].id);
        end
`ifdef STAR_SPAWN_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, m_drop);
`endif
    endtask

    // One clock: check at the falling edge, drive, then advance the model at the rising edge.
    task automatic cyc(input logic p, input logic en, input logic rdy);
        bit   pop, acc;
        exp_t e;
        int   raw;
        check_outputs();
        put_star   = p;
        enable     = en;
        star_ready = rdy;
        @(posedge clk);
        pop = (sbq.size() > 0) && rdy;
        acc = p && en && ((sbq.size() < 4) || pop);
        raw = int'(m_lfsr[9:0]);
        if (raw > 639) raw -= 640;
        if (pop) void'(sbq.pop_front());
        if (acc) begin
            e.x  = raw;
            e.id = m_id;
            sbq.push_back(e);
            m_id = (m_id + 1) % 16;
        end else if (p && en && m_drop < 255) begin
            m_drop++;
        end
        m_lfsr = m_lfsr[0] ? ({1'b0, m_lfsr[15:1]} ^ 16'hB400) : {1'b0, m_lfsr[15:1]};
        @(negedge clk);
    endtask

    task automatic reset_cycle(input logic p);
        resetN   = 1'b0;
        put_star = p;
        enable   = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        resetN   = 1'b1;
        put_star = 1'b0;
        chk("rst_valid", star_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_x", star_x, 0);
        chk("rst_id", star_id, 0);
`ifdef STAR_SPAWN_DROP_CNT_EN
        chk("rst_drop", drop_cnt, 0);
`endif
    endtask

    initial begin
        int ex_x[4];
        ex_x = '{1, 0, 512, 256};
        resetN = 1'b0; put_star = 0; enable = 1; star_ready = 0; put2 = 0; rdy2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_cycle(1'b0);

        // Test 1 and 2: four back-to-back pushes; the second instance captures seed 03FF.
        put2 = 1'b1;
        cyc(1, 1, 0);
        put2 = 1'b0;
        chk("seed_valid", valid2, 1);
        chk("seed_fold_x", x2, 383);
        chk("seed_id", id2, 0);
        cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        chk("t1_full", full, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_x", star_x, ex_x[i]);
            chk("t1_id", star_id, i);
            cyc(0, 1, 1);
        end
        chk("t1_empty", star_valid, 0);

        // Test 3 and 4: overflow drops, then simultaneous push and pop while full.
        reset_cycle(1'b0);
        repeat (4) cyc(1, 1, 0);
        cyc(1, 1, 0); cyc(1, 1, 0);
        chk("t3_full", full, 1);
`ifdef STAR_SPAWN_DROP_CNT_EN
        chk("t3_drop", drop_cnt, 2);
`endif
        chk("t4_head_id", star_id, 0);
        cyc(1, 1, 1);
        chk("t4_full", full, 1);
`ifdef STAR_SPAWN_DROP_CNT_EN
        chk("t4_nodrop", drop_cnt, 2);
`endif
        repeat (3) cyc(0, 1, 1);
        chk("t4_last_id", star_id, 4);
        cyc(0, 1, 1);

        // Test 5: disabled ticks are ignored.
        repeat (3) cyc(1, 0, 0);
        chk("t5_empty", star_valid, 0);
        cyc(0, 1, 0);

        // Test 6: reset with entries queued and a coincident tick.
        cyc(1, 1, 0); cyc(1, 1, 0);
        reset_cycle(1'b1);
        cyc(1, 1, 0);
        chk("t6_id", star_id, 0);
        chk("t6_valid", star_valid, 1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0));
        repeat (6) cyc(0, 1, 1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
